led_tick_counter: RTL and testbench

- Parametrised successor to the board-level seconds counter: a prescaler generates a periodic tick that advances a WIDTH-bit LED counter.
- Adds runtime enable, up/down direction, wrap or saturate mode, synchronous parallel load, a terminal-count pulse, and two debounced pushbutton inputs (clear, manual step).
- Sits between board buttons/PMOD pins and the LED bank; the tick output can drive other blocks in the design.

---
 rtl/led_tick_counter.sv | 129 ++++++++++++
 tb/tb_led_tick_counter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_tick_counter.sv
// Prescaled LED counter with enable, direction, wrap/saturate, parallel load,
// terminal-count pulse and two debounced active-low pushbuttons.

module led_tick_debounce #(
  parameter int DEBOUNCE = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic state
);
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      state <= 1'b1;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any return to the accepted level restarts the stability window.
      if (s2 == state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        state <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module led_tick_counter #(
  parameter int WIDTH    = 4,
  parameter int DIVISOR  = 12000000,
  parameter int SATURATE = 0,
  parameter int DEBOUNCE = 120000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_btn,
  input  logic             step_btn,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);
  localparam int              PW         = $clog2(DIVISOR);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIVISOR - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam bit              SAT        = (SATURATE != 0);

  logic [PW-1:0] presc;
  logic          clr_db;
  logic          step_db;
  logic          step_prev;
  logic          step_fall;
  logic          rollover;
  logic          advance;
  logic          at_bound;

  led_tick_debounce #(.DEBOUNCE(DEBOUNCE)) u_clr_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (clr_btn),
    .state (clr_db)
  );

  led_tick_debounce #(.DEBOUNCE(DEBOUNCE)) u_step_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (step_btn),
    .state (step_db)
  );

  // A press is the debounced 1->0 transition; release is ignored.
  assign step_fall = step_prev & ~step_db;
  assign rollover  = en && (presc == PRESC_LAST);
  assign advance   = rollover | step_fall;
  assign at_bound  = dir ? (count == '0) : (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc     <= '0;
      count     <= '0;
      tick      <= 1'b0;
      tc        <= 1'b0;
      step_prev <= 1'b1;
    end else begin
      step_prev <= step_db;
      // NOTE: pulse outputs default low with non-blocking assignments; a later
      // assignment in the same block wins, so each pulse lasts one cycle.
      tick      <= 1'b0;
      tc        <= 1'b0;
      if (!clr_db) begin
        count <= '0;
        presc <= '0;
      end else begin
        if (en) begin
          if (rollover) begin
            presc <= '0;
            tick  <= 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        if (load) begin
          count <= load_val;
        end else if (advance) begin
          tc <= at_bound;
          if (!(at_bound && SAT)) begin
            count <= dir ? (count - 1'b1) : (count + 1'b1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_led_tick_counter.sv
// Directed bench for led_tick_counter: WIDTH=4, DIVISOR=4, DEBOUNCE=3, with
// one wrapping and one saturating instance sharing the same stimulus.

module tb_led_tick_counter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic       clr_btn;
  logic       step_btn;
  logic [3:0] w_count;
  logic       w_tick;
  logic       w_tc;
  logic [3:0] s_count;
  logic       s_tick;
  logic       s_tc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  led_tick_counter #(.WIDTH(4), .DIVISOR(4), .SATURATE(0), .DEBOUNCE(3)) u_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .clr_btn  (clr_btn),
    .step_btn (step_btn),
    .count    (w_count),
    .tick     (w_tick),
    .tc       (w_tc)
  );

  led_tick_counter #(.WIDTH(4), .DIVISOR(4), .SATURATE(1), .DEBOUNCE(3)) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .clr_btn  (clr_btn),
    .step_btn (step_btn),
    .count    (s_count),
    .tick     (s_tick),
    .tc       (s_tc)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic       sat;
    logic [3:0] count;
    logic       tick;
    logic       tc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic d,
                              input logic l, input logic [3:0] v, input logic s,
                              input logic [3:0] c, input logic t, input logic q);
    vec_t x;
    x.rst_n = r; x.en = e; x.dir = d; x.load = l; x.load_val = v;
    x.sat = s; x.count = c; x.tick = t; x.tc = q;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string name, input logic [3:0] c, input logic t, input logic q);
    check({name, " count"}, 32'(w_count), 32'(c));
    check({name, " tick"}, 32'(w_tick), 32'(t));
    check({name, " tc"}, 32'(w_tc), 32'(q));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'd0;
    clr_btn = 1'b1; step_btn = 1'b1;

    // Wrap instance, running after a full 64-cycle pass: presc=0, count=0.
    add(1,1,0,0, 0,0,  0,0,0);
    add(1,1,0,0, 0,0,  0,0,0);
    add(1,1,0,0, 0,0,  0,0,0);
    add(1,1,0,1, 9,0,  9,1,0);   // load on the tick edge
    add(1,1,0,1,15,0, 15,0,0);
    add(1,0,0,0, 0,0, 15,0,0);   // en low holds the prescaler
    add(1,0,0,0, 0,0, 15,0,0);
    add(1,1,0,0, 0,0, 15,0,0);
    add(1,1,1,0, 0,0, 15,0,0);   // dir toggled mid-period
    add(1,1,0,0, 0,0,  0,1,1);   // 15 -> 0 wrap up
    add(1,1,1,0, 0,0,  0,0,0);
    add(1,1,1,0, 0,0,  0,0,0);
    add(1,1,1,0, 0,0,  0,0,0);
    add(1,1,1,0, 0,0, 15,1,1);   // 0 -> 15 wrap down
    add(1,1,1,0, 0,0, 15,0,0);
    add(1,1,1,1, 0,0,  0,0,0);
    add(1,0,1,0, 0,0,  0,0,0);
    add(1,1,1,1, 0,0,  0,0,0);
    add(1,1,1,1, 0,0,  0,1,0);   // load beats a boundary advance: tc stays low
    add(0,1,1,0, 0,0,  0,0,0);   // reset
    // Saturating instance.
    add(1,0,0,1, 2,1,  2,0,0);
    add(1,1,1,0, 0,1,  2,0,0);
    add(1,1,1,0, 0,1,  2,0,0);
    add(1,1,1,0, 0,1,  2,0,0);
    add(1,1,1,0, 0,1,  1,1,0);
    add(1,1,1,0, 0,1,  1,0,0);
    add(1,1,1,0, 0,1,  1,0,0);
    add(1,1,1,0, 0,1,  1,0,0);
    add(1,1,1,0, 0,1,  0,1,0);
    add(1,1,1,0, 0,1,  0,0,0);
    add(1,1,1,0, 0,1,  0,0,0);
    add(1,1,1,0, 0,1,  0,0,0);
    add(1,1,1,0, 0,1,  0,1,1);   // held at 0, tc fires
    add(1,1,1,0, 0,1,  0,0,0);
    add(1,1,1,0, 0,1,  0,0,0);
    add(1,1,1,0, 0,1,  0,0,0);
    add(1,1,1,0, 0,1,  0,1,1);   // and again
    add(1,1,0,1,14,1, 14,0,0);
    add(1,1,0,0, 0,1, 14,0,0);
    add(1,1,0,0, 0,1, 14,0,0);
    add(1,1,0,0, 0,1, 15,1,0);
    add(1,1,0,0, 0,1, 15,0,0);
    add(1,1,0,0, 0,1, 15,0,0);
    add(1,1,0,0, 0,1, 15,0,0);
    add(1,1,0,0, 0,1, 15,1,1);   // held at 15, tc fires

    // Reset state.
    cyc(); cyc();
    check_w("reset", 4'd0, 1'b0, 1'b0);
    check("reset sat count", 32'(s_count), 32'd0);
    rst_n = 1'b1;

    // Free-running up count: tick every 4 edges, one tc at 15 -> 0.
    en = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      cyc();
      check_w($sformatf("run%0d", k), 4'((k / 4) % 16), (k % 4) == 0, k == 64);
    end

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; dir = vecs[i].dir;
      load = vecs[i].load; load_val = vecs[i].load_val;
      cyc();
      if (vecs[i].sat) begin
        check($sformatf("vec%0d sat count", i), 32'(s_count), 32'(vecs[i].count));
        check($sformatf("vec%0d sat tick", i), 32'(s_tick), 32'(vecs[i].tick));
        check($sformatf("vec%0d sat tc", i), 32'(s_tc), 32'(vecs[i].tc));
      end else begin
        check_w($sformatf("vec%0d", i), vecs[i].count, vecs[i].tick, vecs[i].tc);
      end
    end
    load = 1'b0; dir = 1'b0;

    // Reset mid-period with count=7 discards the prescaler phase.
    en = 1'b1; load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0;
    cyc();
    check("pre-reset count", 32'(w_count), 32'd7);
    rst_n = 1'b0;
    cyc();
    check_w("midreset", 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check_w($sformatf("postreset%0d", k), (k == 4) ? 4'd1 : 4'd0, k == 4, 1'b0);
    end

    // Step press held 10 cycles: one advance on edge 6, nothing on release.
    do_reset();
    step_btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check_w($sformatf("step%0d", k), (k >= 6) ? 4'd1 : 4'd0, 1'b0, 1'b0);
    end
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("release%0d count", k), 32'(w_count), 32'd1);
    end

    // 2-cycle glitch is rejected.
    step_btn = 1'b0;
    cyc(); cyc();
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("glitch%0d count", k), 32'(w_count), 32'd1);
      check($sformatf("glitch%0d tick", k), 32'(w_tick), 32'd0);
    end

    // Step advance lands on the tick edge at count=5: single advance to 6.
    load = 1'b1; load_val = 4'd5;
    cyc();
    load = 1'b0; step_btn = 1'b0;
    cyc(); cyc();
    en = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      cyc();
      check_w($sformatf("coinc%0d", k), 4'd5, 1'b0, 1'b0);
    end
    cyc();
    check_w("coinc6", 4'd6, 1'b1, 1'b0);
    en = 1'b0; step_btn = 1'b1;
    for (int k = 1; k <= 8; k++) cyc();
    check("coinc settle count", 32'(w_count), 32'd6);

    // Clear held while running, then released.
    do_reset();
    en = 1'b1; clr_btn = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k <= 4) check_w($sformatf("clr%0d", k), (k == 4) ? 4'd1 : 4'd0, k == 4, 1'b0);
      else if (k >= 6) check_w($sformatf("clr%0d", k), 4'd0, 1'b0, 1'b0);
    end
    clr_btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check_w($sformatf("unclr%0d", k), (k == 9) ? 4'd1 : 4'd0, k == 9, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
